fib_bcd_converter: RTL and testbench
====================================

FIB_BCD_CONVERTER -- requirements
Module: fib_bcd_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the binary input width.
REQ-002 The block SHALL have parameter DIGITS, default 10, giving the BCD output digit count; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH - 1.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, in_value is valid this cycle.
REQ-006 The block SHALL have port in_value, input, WIDTH, unsigned binary term from the upstream Fibonacci generator.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a term.
REQ-008 The block SHALL have port out_valid, output, 1, out_bcd holds a completed conversion.
REQ-009 The block SHALL have port out_bcd, output, 4*DIGITS, packed BCD result, least significant digit in bits [3:0].
REQ-010 The block SHALL have port out_ready, input, 1, downstream accepts out_bcd.
REQ-011 The block SHALL have port busy, output, 1, high while a conversion is in progress (state SHIFT).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in SHIFT.
REQ-014 An input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_value SHALL be captured into an internal binary shift register, the BCD accumulator cleared to 0, the bit counter loaded with WIDTH, and the FSM SHALL move to SHIFT.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble step: every BCD digit >= 5 gets +3, then {BCD accumulator, binary register} shifts left by one, the binary MSB entering BCD bit 0; the bit counter decrements.
REQ-016 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE; out_valid SHALL therefore rise WIDTH+1 rising edges after the handshake edge, counting the handshake edge.
REQ-017 in_value changes after the handshake edge SHALL NOT affect the result.
REQ-018 In DONE, out_bcd and out_valid SHALL remain stable until a rising edge with out_ready=1, upon which the FSM SHALL return to IDLE.
REQ-019 The block SHALL NOT accept a new input in the cycle it leaves DONE; in_ready rises only once the FSM is in IDLE.
REQ-020 out_bcd SHALL hold its last completed value in IDLE and SHIFT; intermediate accumulator contents SHALL NOT appear on out_bcd.
REQ-021 in_valid asserted while in SHIFT or DONE SHALL be ignored, with no capture and no state change.
REQ-022 Input value 0 SHALL still take the full WIDTH SHIFT cycles and yield out_bcd = 0.
REQ-023 No BCD digit SHALL ever exceed 9 in out_bcd; digits above the most significant nonzero digit SHALL be 0.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, with out_valid=0, busy=0, in_ready=1 after the edge, out_bcd=0, and the internal registers and counter cleared.
REQ-025 reset SHALL take priority over every handshake and over a conversion in progress; a conversion aborted by reset SHALL never produce out_valid.
REQ-026 During reset the upstream generator drives value=0; the block SHALL treat in_valid/in_value like any other input once reset is released.

Verification
REQ-027 WIDTH=32, DIGITS=10, in_value=0 -> out_valid rises 33 edges after the handshake, out_bcd=0.
REQ-028 WIDTH=32, in_value=1836311903 (Fibonacci term 46) -> out_bcd=0x1836311903 in BCD nibbles; in_value=4294967295 -> out_bcd=0x4294967295.
REQ-029 WIDTH=8, DIGITS=3, feed the sequence 0,1,1,2,3,5,8,13,21,34,55,89,144,233 back-to-back with in_valid held high and out_ready=1 -> the BCD results match in order, and each new handshake occurs exactly one cycle after out_valid falls.
REQ-030 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_bcd stays stable, in_ready stays 0; out_ready=1 -> the FSM enters IDLE on the next edge.
REQ-031 Assert reset during SHIFT (after 10 SHIFT cycles, WIDTH=32) -> the next edge gives busy=0, out_valid=0, out_bcd=0, in_ready=1; a subsequent input of 55 gives out_bcd=0x55.
REQ-032 Toggle in_value and in_valid during SHIFT -> the result equals the BCD of the originally captured value.

Source files
------------

// File: rtl/fib_bcd_converter_if.sv
// Handshake bundle between the Fibonacci generator, the BCD converter and
// the downstream consumer. The converter is the slave side.
interface fib_bcd_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_value;
  logic                  in_ready;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_bcd, busy
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_bcd, busy
  );
endinterface

// File: rtl/fib_bcd_converter.sv
// Sequential double-dabble binary to BCD converter, one bit per clock.
// A captured term is shifted out MSB first into a BCD accumulator; the
// finished result is copied to a separate output register so partial
// accumulator contents never reach out_bcd.
module fib_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  fib_bcd_converter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] bin_reg;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_next;
  logic [BW-1:0]    result;
  logic [CW-1:0]    count;
  logic             last_step;

  // State register; reset wins over any handshake or running conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the per-state handshake outputs.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    last_step     = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (count == CW'(1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the binary MSB.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_next = (acc_adj << 1) | BW'(bin_reg[WIDTH-1]);
  end

  // Datapath: capture on handshake, shift while converting, publish on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_reg <= '0;
      acc     <= '0;
      count   <= '0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin_reg <= bus.in_value;
            acc     <= '0;
            count   <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          bin_reg <= bin_reg << 1;
          acc     <= acc_next;
          count   <= count - CW'(1);
          if (last_step) begin
            result <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_bcd = result;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Self-checking bench for fib_bcd_converter: a 32-bit instance exercised with
// directed and random terms, and an 8-bit instance fed a Fibonacci stream
// back-to-back. Expected BCD comes from a decimal-digit model.
module tb_fib_bcd_converter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fib_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) ifa ();
  fib_bcd_converter_if #(.WIDTH(8),  .DIGITS(3))  ifb ();

  fib_bcd_converter #(.WIDTH(32), .DIGITS(10)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  fib_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int          checks = 0;
  int          passed = 0;
  int          failed = 0;
  logic [63:0] last_a = '0;

  int unsigned seq [14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  // Decimal digits by repeated division, packed one per nibble.
  function automatic logic [63:0] to_bcd(input longint unsigned v);
    logic [63:0]     r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Convert one term on the 32-bit instance, scrambling inputs while it works,
  // then optionally stall the consumer before releasing the result.
  task automatic applyStimulus(input logic [31:0] v, input int hold_cycles);
    int latency;
    ifa.in_valid = 1'b1;
    ifa.in_value = v;
    tick();
    latency = 1;
    ifa.in_valid = 1'b0;
    checkOutput("a_busy_after_handshake", {ifa.in_ready, ifa.out_valid, ifa.busy}, 3'b001);
    checkOutput("a_bcd_held_in_shift", ifa.out_bcd, last_a);
    while (!ifa.out_valid && latency < 100) begin
      ifa.in_valid = 1'($urandom_range(0, 1));
      ifa.in_value = $urandom;
      tick();
      latency++;
    end
    ifa.in_valid = 1'b0;
    checkOutput("a_latency", latency, 33);
    checkOutput("a_bcd", ifa.out_bcd, to_bcd(v));
    for (int i = 0; i < hold_cycles; i++) begin
      ifa.out_ready = 1'b0;
      ifa.in_valid  = 1'b1;
      ifa.in_value  = $urandom;
      tick();
      checkOutput("a_hold_flags", {ifa.in_ready, ifa.out_valid, ifa.busy}, 3'b010);
      checkOutput("a_hold_bcd", ifa.out_bcd, to_bcd(v));
    end
    ifa.in_valid  = 1'b1;
    ifa.out_ready = 1'b1;
    tick();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b0;
    checkOutput("a_idle_after_release", {ifa.in_ready, ifa.out_valid, ifa.busy}, 3'b100);
    checkOutput("a_bcd_held_in_idle", ifa.out_bcd, to_bcd(v));
    last_a = to_bcd(v);
  endtask

  initial begin
    int   idx_in;
    int   idx_out;
    int   since;
    logic hs;
    logic prev_valid;
    logic seen_valid;

    $display("[TB] starting fib_bcd_converter bench");
    reset         = 1'b1;
    ifa.in_valid  = 1'b0;
    ifa.in_value  = '0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.in_value  = '0;
    ifb.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("a_reset_flags", {ifa.in_ready, ifa.out_valid, ifa.busy}, 3'b100);
    checkOutput("a_reset_bcd", ifa.out_bcd, 64'd0);
    checkOutput("b_reset_flags", {ifb.in_ready, ifb.out_valid, ifb.busy}, 3'b100);
    checkOutput("b_reset_bcd", ifb.out_bcd, 64'd0);
    reset = 1'b0;

    applyStimulus(32'd0, 0);
    applyStimulus(32'd1836311903, 5);
    applyStimulus(32'hFFFF_FFFF, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom, i % 3);
    end

    $display("[TB] reset during conversion");
    ifa.in_valid = 1'b1;
    ifa.in_value = $urandom;
    tick();
    ifa.in_valid = 1'b0;
    repeat (10) tick();
    checkOutput("a_busy_before_abort", ifa.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("a_abort_flags", {ifa.in_ready, ifa.out_valid, ifa.busy}, 3'b100);
    checkOutput("a_abort_bcd", ifa.out_bcd, 64'd0);
    last_a = '0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen_valid = seen_valid | ifa.out_valid;
    end
    checkOutput("a_no_valid_after_abort", seen_valid, 1'b0);
    applyStimulus(32'd55, 1);

    $display("[TB] back-to-back Fibonacci stream on 8-bit instance");
    ifb.out_ready = 1'b1;
    ifb.in_valid  = 1'b1;
    ifb.in_value  = 8'(seq[0]);
    idx_in     = 0;
    idx_out    = 0;
    since      = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && idx_out < 14; cyc++) begin
      hs = ifb.in_ready & ifb.in_valid;
      tick();
      if (hs) begin
        idx_in++;
        since = 1;
        ifb.in_valid = (idx_in < 14);
        ifb.in_value = (idx_in < 14) ? 8'(seq[idx_in]) : 8'd0;
      end else begin
        since++;
      end
      if (ifb.out_valid && !prev_valid && idx_out < 14) begin
        checkOutput("b_latency", since, 9);
        checkOutput("b_bcd", ifb.out_bcd, to_bcd(seq[idx_out]));
        idx_out++;
      end
      if (!ifb.out_valid && prev_valid) begin
        checkOutput("b_ready_after_done", {ifb.in_ready, ifb.busy}, 2'b10);
      end
      prev_valid = ifb.out_valid;
    end
    checkOutput("b_result_count", idx_out, 14);
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
